// File: rtl/axil_timeout_guard_pkg.sv
// Shared channel state and AXI response codes
// for the AXI-lite response-timeout guard.
package axil_timeout_guard_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } chan_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_timeout_timer.sv
// Response-phase timer: clear/enable up-counter.
// Ports: clk, rst, clear, enable in; expired out (count == TIMEOUT-1).
module axil_timeout_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/axil_timeout_guard.sv
// AXI-lite response-timeout guard: one write and one read in flight,
// SLVERR on timeout, late slave responses drained silently.
// Ports: clk, rst; s_axil_* upstream; m_axil_* downstream;
// wr_timeout/rd_timeout pulses; wr/rd_timeout_count when
// AXIL_TIMEOUT_GUARD_STATS_EN is defined.
module axil_timeout_guard
  import axil_timeout_guard_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 1024,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  wr_timeout,
  output logic                  rd_timeout
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] wr_timeout_count,
  output logic [STAT_WIDTH-1:0] rd_timeout_count
`endif
);

  chan_state_t wr_st, rd_st;
  logic wr_late, rd_late;
  logic wr_expired, rd_expired;
  logic wr_accept, rd_accept;
  logic aw_fin, w_fin, ar_fin;
  logic wr_to_evt, rd_to_evt;
  logic wr_in_wait, rd_in_wait;

  assign wr_in_wait = (wr_st == WAIT);
  assign rd_in_wait = (rd_st == WAIT);

  // AW and W are only taken together, so ready follows both valids.
  assign wr_accept = (wr_st == IDLE)
                   & s_axil_awvalid & s_axil_wvalid;
  assign rd_accept = (rd_st == IDLE) & s_axil_arvalid;
  assign s_axil_awready = wr_accept;
  assign s_axil_wready  = wr_accept;
  assign s_axil_arready = rd_accept;

  assign aw_fin = !m_axil_awvalid || m_axil_awready;
  assign w_fin  = !m_axil_wvalid  || m_axil_wready;
  assign ar_fin = !m_axil_arvalid || m_axil_arready;

  // A real response in the expiry cycle takes priority.
  assign wr_to_evt = wr_in_wait && !m_axil_bvalid && wr_expired;
  assign rd_to_evt = rd_in_wait && !m_axil_rvalid && rd_expired;

  axil_timeout_timer #(.TIMEOUT(TIMEOUT)) u_wr_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wr_in_wait),
    .enable  (wr_in_wait),
    .expired (wr_expired)
  );

  axil_timeout_timer #(.TIMEOUT(TIMEOUT)) u_rd_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!rd_in_wait),
    .enable  (rd_in_wait),
    .expired (rd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st          <= IDLE;
      wr_late        <= 1'b0;
      wr_timeout     <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_awprot  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      wr_timeout <= 1'b0;
      unique case (wr_st)
        IDLE: if (wr_accept) begin
          m_axil_awaddr  <= s_axil_awaddr;
          m_axil_awprot  <= s_axil_awprot;
          m_axil_wdata   <= s_axil_wdata;
          m_axil_wstrb   <= s_axil_wstrb;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
          wr_st          <= ISSUE;
        end
        ISSUE: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axil_bready <= 1'b1;
            wr_st         <= WAIT;
          end
        end
        WAIT: if (m_axil_bvalid) begin
          s_axil_bresp  <= m_axil_bresp;
          s_axil_bvalid <= 1'b1;
          m_axil_bready <= 1'b0;
          wr_late       <= 1'b0;
          wr_st         <= RESP;
        end else if (wr_to_evt) begin
          s_axil_bresp  <= RESP_SLVERR;
          s_axil_bvalid <= 1'b1;
          m_axil_bready <= 1'b0;
          wr_timeout    <= 1'b1;
          wr_late       <= 1'b1;
          wr_st         <= RESP;
        end
        RESP: if (s_axil_bready) begin
          s_axil_bvalid <= 1'b0;
          m_axil_bready <= wr_late;
          wr_st         <= wr_late ? DRAIN : IDLE;
        end
        DRAIN: if (m_axil_bvalid) begin
          m_axil_bready <= 1'b0;
          wr_late       <= 1'b0;
          wr_st         <= IDLE;
        end
        default: wr_st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_st          <= IDLE;
      rd_late        <= 1'b0;
      rd_timeout     <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arprot  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
    end else begin
      rd_timeout <= 1'b0;
      unique case (rd_st)
        IDLE: if (rd_accept) begin
          m_axil_araddr  <= s_axil_araddr;
          m_axil_arprot  <= s_axil_arprot;
          m_axil_arvalid <= 1'b1;
          rd_st          <= ISSUE;
        end
        ISSUE: if (ar_fin) begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b1;
          rd_st          <= WAIT;
        end
        WAIT: if (m_axil_rvalid) begin
          s_axil_rdata  <= m_axil_rdata;
          s_axil_rresp  <= m_axil_rresp;
          s_axil_rvalid <= 1'b1;
          m_axil_rready <= 1'b0;
          rd_late       <= 1'b0;
          rd_st         <= RESP;
        end else if (rd_to_evt) begin
          s_axil_rdata  <= '0;
          s_axil_rresp  <= RESP_SLVERR;
          s_axil_rvalid <= 1'b1;
          m_axil_rready <= 1'b0;
          rd_timeout    <= 1'b1;
          rd_late       <= 1'b1;
          rd_st         <= RESP;
        end
        RESP: if (s_axil_rready) begin
          s_axil_rvalid <= 1'b0;
          m_axil_rready <= rd_late;
          rd_st         <= rd_late ? DRAIN : IDLE;
        end
        DRAIN: if (m_axil_rvalid) begin
          m_axil_rready <= 1'b0;
          rd_late       <= 1'b0;
          rd_st         <= IDLE;
        end
        default: rd_st <= IDLE;
      endcase
    end
  end

`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_timeout_count <= '0;
      rd_timeout_count <= '0;
    end else begin
      if (wr_to_evt && !(&wr_timeout_count))
        wr_timeout_count <= wr_timeout_count + STAT_WIDTH'(1);
      if (rd_to_evt && !(&rd_timeout_count))
        rd_timeout_count <= rd_timeout_count + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axil_timeout_guard.sv
// Self-checking bench for axil_timeout_guard: directed and
// randomized transactions against a cycle-count response model.
module tb_axil_timeout_guard;

  localparam int TMO = 16;
  localparam int SW  = 2;
  localparam int SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rvalid, s_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready;
  logic        wr_timeout, rd_timeout;
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
  logic [SW-1:0] wr_timeout_count, rd_timeout_count;
`endif

  axil_timeout_guard #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (TMO),
    .STAT_WIDTH (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_awaddr),
    .s_axil_awprot  (s_awprot),
    .s_axil_awvalid (s_awvalid),
    .s_axil_awready (s_awready),
    .s_axil_wdata   (s_wdata),
    .s_axil_wstrb   (s_wstrb),
    .s_axil_wvalid  (s_wvalid),
    .s_axil_wready  (s_wready),
    .s_axil_bresp   (s_bresp),
    .s_axil_bvalid  (s_bvalid),
    .s_axil_bready  (s_bready),
    .s_axil_araddr  (s_araddr),
    .s_axil_arprot  (s_arprot),
    .s_axil_arvalid (s_arvalid),
    .s_axil_arready (s_arready),
    .s_axil_rdata   (s_rdata),
    .s_axil_rresp   (s_rresp),
    .s_axil_rvalid  (s_rvalid),
    .s_axil_rready  (s_rready),
    .m_axil_awaddr  (m_awaddr),
    .m_axil_awprot  (m_awprot),
    .m_axil_awvalid (m_awvalid),
    .m_axil_awready (m_awready),
    .m_axil_wdata   (m_wdata),
    .m_axil_wstrb   (m_wstrb),
    .m_axil_wvalid  (m_wvalid),
    .m_axil_wready  (m_wready),
    .m_axil_bresp   (m_bresp),
    .m_axil_bvalid  (m_bvalid),
    .m_axil_bready  (m_bready),
    .m_axil_araddr  (m_araddr),
    .m_axil_arprot  (m_arprot),
    .m_axil_arvalid (m_arvalid),
    .m_axil_arready (m_arready),
    .m_axil_rdata   (m_rdata),
    .m_axil_rresp   (m_rresp),
    .m_axil_rvalid  (m_rvalid),
    .m_axil_rready  (m_rready),
    .wr_timeout     (wr_timeout),
    .rd_timeout     (rd_timeout)
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
    ,
    .wr_timeout_count (wr_timeout_count),
    .rd_timeout_count (rd_timeout_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_wc = 0;
  int exp_rc = 0;
  time wr_pt = 0;
  time rd_pt = 0;

  always @(negedge clk) begin
    if (wr_timeout) wr_pt = $time;
    if (rd_timeout) rd_pt = $time;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  // lat: cycles after the timer starts before the slave answers;
  // lat >= TMO means the answer only comes after the timeout.
  task automatic wr_txn(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] st,
                        input int aw_d, input int w_d,
                        input int lat, input logic [1:0] br,
                        input int drain_d);
    bit to;
    bit aw_dn, w_dn;
    int i, j, pulses;
    to = (lat >= TMO);
    if (to) exp_wc++;
    s_awaddr = a; s_awprot = a[2:0];
    s_wdata = d; s_wstrb = st;
    s_awvalid = 1; s_wvalid = 1;
    #1 chk("wr_accept", {s_awready, s_wready}, 2'b11);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    chk("wr_addr", {m_awprot, m_awaddr}, {a[2:0], a});
    chk("wr_data", {m_wstrb, m_wdata}, {st, d});
    aw_dn = 0; w_dn = 0; j = 0;
    while (!(aw_dn && w_dn) && j < 20) begin
      chk("wr_awvalid", m_awvalid, !aw_dn);
      chk("wr_wvalid", m_wvalid, !w_dn);
      m_awready = !aw_dn && (j >= aw_d);
      m_wready  = !w_dn && (j >= w_d);
      @(negedge clk);
      if (m_awready) aw_dn = 1;
      if (m_wready) w_dn = 1;
      j++;
    end
    m_awready = 0; m_wready = 0;
    chk("wr_issue_done", {m_awvalid, m_wvalid}, 2'b00);
    pulses = 0; i = 0;
    while (!s_bvalid && i < 3 * TMO) begin
      if (wr_timeout) pulses++;
      if (!to && i == lat) begin
        m_bvalid = 1; m_bresp = br;
      end
      @(negedge clk);
      i++;
      if (!to && i == lat + 1) m_bvalid = 0;
    end
    m_bvalid = 0;
    chk("wr_latency", i, to ? TMO : lat + 1);
    chk("wr_early_pulse", pulses, 0);
    chk("wr_pulse", wr_timeout, to);
    chk("wr_bresp", s_bresp, to ? 2'b10 : br);
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
    chk("wr_bvalid_drop", {s_bvalid, wr_timeout}, 2'b00);
    if (to) begin
      for (int k = 0; k < drain_d; k++) begin
        chk("wr_drain_bready", m_bready, 1);
        s_awvalid = 1; s_wvalid = 1;
        #1 chk("wr_drain_block", s_awready, 0);
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk);
      end
      chk("wr_drain_bready", m_bready, 1);
      m_bvalid = 1; m_bresp = 2'b01;
      @(negedge clk);
      m_bvalid = 0;
      repeat (2) begin
        chk("wr_drain_hidden", {s_bvalid, m_bready}, 2'b00);
        @(negedge clk);
      end
    end
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
    chk("wr_count", wr_timeout_count, sat(exp_wc));
`endif
  endtask

  task automatic rd_txn(input logic [31:0] a,
                        input logic [2:0] pr,
                        input int ar_d, input int lat,
                        input logic [31:0] rd,
                        input logic [1:0] rr,
                        input int drain_d);
    bit to;
    bit dn;
    int i, j, pulses;
    to = (lat >= TMO);
    if (to) exp_rc++;
    s_araddr = a; s_arprot = pr; s_arvalid = 1;
    #1 chk("rd_accept", s_arready, 1);
    @(negedge clk);
    s_arvalid = 0;
    chk("rd_addr", {m_arprot, m_araddr}, {pr, a});
    dn = 0; j = 0;
    while (!dn && j < 20) begin
      chk("rd_arvalid", m_arvalid, 1);
      m_arready = (j >= ar_d);
      @(negedge clk);
      if (m_arready) dn = 1;
      j++;
    end
    m_arready = 0;
    chk("rd_issue_done", m_arvalid, 0);
    pulses = 0; i = 0;
    while (!s_rvalid && i < 3 * TMO) begin
      if (rd_timeout) pulses++;
      if (!to && i == lat) begin
        m_rvalid = 1; m_rdata = rd; m_rresp = rr;
      end
      @(negedge clk);
      i++;
      if (!to && i == lat + 1) m_rvalid = 0;
    end
    m_rvalid = 0;
    chk("rd_latency", i, to ? TMO : lat + 1);
    chk("rd_early_pulse", pulses, 0);
    chk("rd_pulse", rd_timeout, to);
    chk("rd_rresp", s_rresp, to ? 2'b10 : rr);
    chk("rd_rdata", s_rdata, to ? 32'h0 : rd);
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;
    chk("rd_rvalid_drop", {s_rvalid, rd_timeout}, 2'b00);
    if (to) begin
      for (int k = 0; k < drain_d; k++) begin
        chk("rd_drain_rready", m_rready, 1);
        s_arvalid = 1;
        #1 chk("rd_drain_block", s_arready, 0);
        s_arvalid = 0;
        @(negedge clk);
      end
      chk("rd_drain_rready", m_rready, 1);
      m_rvalid = 1; m_rdata = rd; m_rresp = 2'b00;
      @(negedge clk);
      m_rvalid = 0;
      repeat (2) begin
        chk("rd_drain_hidden", {s_rvalid, m_rready}, 2'b00);
        @(negedge clk);
      end
    end
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
    chk("rd_count", rd_timeout_count, sat(exp_rc));
`endif
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"},
        {s_awready, s_wready, s_bvalid, s_arready,
         s_rvalid, m_awvalid, m_wvalid, m_bready,
         m_arvalid, m_rready, wr_timeout, rd_timeout},
        12'h0);
    chk({tag, "_resp"}, {s_bresp, s_rresp, s_rdata}, 36'h0);
`ifdef AXIL_TIMEOUT_GUARD_STATS_EN
    chk({tag, "_cnt"}, {wr_timeout_count, rd_timeout_count}, 0);
`endif
  endtask

  initial begin
    int sel, lat, nb;
    rst = 1;
    s_awaddr = 0; s_awprot = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arprot = 0; s_arvalid = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;
    @(negedge clk);

    wr_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 3, 2'b00, 0);
    rd_txn(32'h20, 3'd0, 0, 1000, 32'h1234, 2'b00, 3);
    rd_txn(32'h24, 3'd1, 0, 2, 32'hCAFE0001, 2'b00, 0);
    wr_txn(32'h30, 32'h5555AAAA, 4'h3, 1, 2, TMO - 1,
           2'b01, 0);
    rd_txn(32'h34, 3'd2, 2, TMO, 32'h77, 2'b00, 0);
    wr_txn(32'h38, 32'h0, 4'h1, 0, 0, 0, 2'b11, 0);

    fork
      wr_txn(32'h40, 32'h1, 4'hF, 0, 0, 500, 2'b00, 1);
      rd_txn(32'h44, 3'd0, 0, 500, 32'h2, 2'b00, 1);
    join
    chk("both_pulse_same_cycle", wr_pt, rd_pt);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0)
        lat = TMO + $urandom_range(0, 5);
      else
        lat = $urandom_range(0, TMO - 1);
      if (sel == 0)
        wr_txn($urandom, $urandom, 4'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3),
               lat, 2'($urandom), $urandom_range(0, 4));
      else
        rd_txn($urandom, 3'($urandom),
               $urandom_range(0, 3), lat, $urandom,
               2'($urandom), $urandom_range(0, 4));
    end

    s_awaddr = 32'h50; s_wdata = 32'h99; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    m_awready = 1; m_wready = 1;
    @(negedge clk);
    m_awready = 0; m_wready = 0;
    repeat (3) @(negedge clk);
    chk("rst_pre_wait", m_bready, 1);
    rst = 1;
    exp_wc = 0; exp_rc = 0;
    #1 chk_idle_outputs("rst_async");
    @(negedge clk);
    rst = 0;
    nb = 0;
    repeat (2 * TMO) begin
      @(negedge clk);
      if (s_bvalid || wr_timeout) nb++;
    end
    chk("rst_no_late_b", nb, 0);

    for (int n = 0; n < SAT + 2; n++) begin
      fork
        wr_txn(32'h60 + n, n, 4'hF, 0, 0, 200, 2'b00, 0);
        rd_txn(32'h64 + n, 3'd0, 0, 200, n, 2'b00, 0);
      join
      chk("sat_pulse_same_cycle", wr_pt, rd_pt);
    end

    wr_txn(32'h70, 32'hFACE, 4'hC, 0, 1, 5, 2'b00, 0);
    rd_txn(32'h74, 3'd5, 1, 5, 32'hBEEF, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
